// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : Stall/flush sequencer for a 5-stage MIPS pipeline. Resolves
//            memory waits, M-stage jump redirects, fixed-latency divides and
//            load-use hazards. Drives the pipeline register enables/clears.
// Revision : 1.0  initial release
// ============================================================================
module pipeline_hazard_controller #(
  parameter int WIDTH_5     = 5,
  parameter int DIV_CYCLES  = 32,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH_5-1:0] Rs_D,
  input  logic [WIDTH_5-1:0] Rt_D,
  input  logic               MemtoReg_E,
  input  logic [WIDTH_5-1:0] WriteReg_E,
  input  logic               div_start_E,
  input  logic               J_M,
  input  logic               Jr_M,
  input  logic               MemtoReg_M,
  input  logic               MemWrite_M,
  input  logic               mem_ready,
  output logic               EN_F,
  output logic               EN_D,
  output logic               CLR_D,
  output logic               EN_E,
  output logic               CLR_E,
  output logic               EN_M,
  output logic               CLR_M,
  output logic               EN_W,
  output logic               CLR_W,
  output logic               div_go,
  output logic               div_busy,
  output logic               mem_timeout
);

  localparam int CNT_W  = $clog2(DIV_CYCLES) + 1;
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    DIV_WAIT = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [CNT_W-1:0]   div_cnt, div_cnt_next;
  logic [WAIT_W-1:0]  wait_cnt;
  logic               timeout_flag;

  logic mem_wait;
  logic redirect;
  logic load_use;

  // Un-gated control values; reset masking is applied at the ports.
  logic en_f, en_d, clr_d, en_e, clr_e, en_m, clr_m, en_w, clr_w, go;

  assign mem_wait = (MemtoReg_M | MemWrite_M) & ~mem_ready;
  assign redirect = J_M | Jr_M;
  assign load_use = MemtoReg_E & (WriteReg_E != '0) &
                    ((WriteReg_E == Rs_D) | (WriteReg_E == Rt_D));

  // State and divide counter; both freeze while memory is stalling.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      div_cnt <= '0;
    end else begin
      state   <= state_next;
      div_cnt <= div_cnt_next;
    end
  end

  // Consecutive memory-wait counter (saturating) and sticky timeout flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (mem_wait) begin
        if (wait_cnt != WAIT_MAX) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end
      end else begin
        wait_cnt <= '0;
      end
      if (wait_cnt == WAIT_MAX) begin
        timeout_flag <= 1'b1;
      end
    end
  end

  // Priority resolution: mem_wait > redirect > divide wait > divide start > load-use.
  always_comb begin
    state_next   = state;
    div_cnt_next = div_cnt;
    en_f  = 1'b1;
    en_d  = 1'b1;
    en_e  = 1'b1;
    en_m  = 1'b1;
    en_w  = 1'b1;
    clr_d = 1'b0;
    clr_e = 1'b0;
    clr_m = 1'b0;
    clr_w = 1'b0;
    go    = 1'b0;

    if (mem_wait) begin
      // Everything up to M holds; W takes a bubble so the access is not retired.
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      en_m  = 1'b0;
      clr_w = 1'b1;
    end else if (redirect) begin
      // Squash the three younger instructions; any divide in flight is younger.
      clr_d = 1'b1;
      clr_e = 1'b1;
      clr_m = 1'b1;
      if (state == DIV_WAIT) begin
        state_next   = RUN;
        div_cnt_next = '0;
      end
    end else if (state == DIV_WAIT) begin
      if (div_cnt != '0) begin
        en_f  = 1'b0;
        en_d  = 1'b0;
        en_e  = 1'b0;
        clr_m = 1'b1;
        div_cnt_next = div_cnt - CNT_W'(1);
      end else begin
        // Release cycle: defaults, and a still-high div_start_E is ignored.
        state_next = RUN;
      end
    end else if (div_start_E) begin
      // Divide stall also covers any concurrent load-use hazard.
      go    = 1'b1;
      en_f  = 1'b0;
      en_d  = 1'b0;
      en_e  = 1'b0;
      clr_m = 1'b1;
      div_cnt_next = DIV_LOAD;
      state_next   = DIV_WAIT;
    end else if (load_use) begin
      en_f  = 1'b0;
      en_d  = 1'b0;
      clr_e = 1'b1;
    end
  end

  // All control outputs are forced low while reset is asserted.
  assign EN_F        = rst_n & en_f;
  assign EN_D        = rst_n & en_d;
  assign CLR_D       = rst_n & clr_d;
  assign EN_E        = rst_n & en_e;
  assign CLR_E       = rst_n & clr_e;
  assign EN_M        = rst_n & en_m;
  assign CLR_M       = rst_n & clr_m;
  assign EN_W        = rst_n & en_w;
  assign CLR_W       = rst_n & clr_w;
  assign div_go      = rst_n & go;
  assign div_busy    = rst_n & (state == DIV_WAIT);
  assign mem_timeout = timeout_flag;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_hazard_controller
// Purpose  : Self-checking bench: constant vector table, directed multi-cycle
//            sequences and randomized traffic against a reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_hazard_controller;

  localparam int DIV_CYCLES  = 32;
  localparam int MEM_TIMEOUT = 15;

  // Output vector order: EN_F EN_D CLR_D EN_E CLR_E EN_M CLR_M EN_W CLR_W div_go div_busy mem_timeout
  localparam logic [11:0] O_DEF = 12'b1_1_0_1_0_1_0_1_0_0_0_0;
  localparam logic [11:0] O_LU  = 12'b0_0_0_1_1_1_0_1_0_0_0_0;
  localparam logic [11:0] O_RED = 12'b1_1_1_1_1_1_1_1_0_0_0_0;
  localparam logic [11:0] O_MW  = 12'b0_0_0_0_0_0_0_1_1_0_0_0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] Rs_D, Rt_D, WriteReg_E;
  logic       MemtoReg_E, div_start_E, J_M, Jr_M, MemtoReg_M, MemWrite_M, mem_ready;
  logic       EN_F, EN_D, CLR_D, EN_E, CLR_E, EN_M, CLR_M, EN_W, CLR_W;
  logic       div_go, div_busy, mem_timeout;

  always #5 clk = ~clk;

  pipeline_hazard_controller #(
    .WIDTH_5(5), .DIV_CYCLES(DIV_CYCLES), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .Rs_D(Rs_D), .Rt_D(Rt_D), .MemtoReg_E(MemtoReg_E),
    .WriteReg_E(WriteReg_E), .div_start_E(div_start_E), .J_M(J_M), .Jr_M(Jr_M),
    .MemtoReg_M(MemtoReg_M), .MemWrite_M(MemWrite_M), .mem_ready(mem_ready),
    .EN_F(EN_F), .EN_D(EN_D), .CLR_D(CLR_D), .EN_E(EN_E), .CLR_E(CLR_E),
    .EN_M(EN_M), .CLR_M(CLR_M), .EN_W(EN_W), .CLR_W(CLR_W),
    .div_go(div_go), .div_busy(div_busy), .mem_timeout(mem_timeout)
  );

  logic [11:0] dut_out;
  assign dut_out = {EN_F, EN_D, CLR_D, EN_E, CLR_E, EN_M, CLR_M, EN_W, CLR_W,
                    div_go, div_busy, mem_timeout};

  // ---------------- reference model ----------------
  // Tracks: whether a divide is outstanding and how many stall cycles remain
  // after its acceptance cycle, the length of the current memory-wait streak,
  // and the sticky timeout.
  logic m_busy;
  int   m_left;
  int   m_streak;
  logic m_tmo;
  logic [11:0] exp_out;
  logic x_mw, x_rd, x_lu;
  logic [9:0] x_ctl;

  assign x_mw = (MemtoReg_M | MemWrite_M) & !mem_ready;
  assign x_rd = J_M | Jr_M;
  assign x_lu = MemtoReg_E && (WriteReg_E != 0) && (WriteReg_E == Rs_D || WriteReg_E == Rt_D);

  // Expected outputs for the current cycle.
  always_comb begin
    if (x_mw)                              x_ctl = O_MW[11:2];
    else if (x_rd)                         x_ctl = O_RED[11:2];
    else if (m_busy && m_left > 0)         x_ctl = 10'b0_0_0_0_0_1_1_1_0_0;
    else if (m_busy)                       x_ctl = O_DEF[11:2];
    else if (div_start_E)                  x_ctl = 10'b0_0_0_0_0_1_1_1_0_1;
    else if (x_lu)                         x_ctl = O_LU[11:2];
    else                                   x_ctl = O_DEF[11:2];
    exp_out = rst_n ? {x_ctl, m_busy, m_tmo} : 12'b0;
  end

  // Model state advance at each rising edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_left <= 0; m_streak <= 0; m_tmo <= 1'b0;
    end else begin
      if (m_streak >= MEM_TIMEOUT) m_tmo <= 1'b1;
      m_streak <= x_mw ? m_streak + 1 : 0;
      if (x_mw) begin
        // frozen
      end else if (x_rd) begin
        m_busy <= 1'b0; m_left <= 0;
      end else if (m_busy) begin
        if (m_left > 0) m_left <= m_left - 1;
        else            m_busy <= 1'b0;
      end else if (div_start_E) begin
        m_busy <= 1'b1; m_left <= DIV_CYCLES - 1;
      end
    end
  end

  // ---------------- checking helpers ----------------
  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sample(input string name);
    @(negedge clk);
    chk(name, dut_out, exp_out);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    Rs_D = 0; Rt_D = 0; WriteReg_E = 0; MemtoReg_E = 0; div_start_E = 0;
    J_M = 0; Jr_M = 0; MemtoReg_M = 0; MemWrite_M = 0; mem_ready = 1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    sample("reset_model");
    chk("reset_state", dut_out, 12'b0);
    adv();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0] rs, rt, wr;
    logic       mtr_e, j, jr, mtr_m, mw_m, rdy;
    logic [11:0] exp;
  } vec_t;

  vec_t tbl [12];
  int   go_count;
  int   ene_low;
  int   burst;

  initial begin
    //              rs  rt  wr mtrE j  jr mtrM mwM rdy  expected
    tbl[0]  = '{5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, 0, O_DEF};
    tbl[1]  = '{5'd5, 5'd2, 5'd5, 1, 0, 0, 0, 0, 1, O_LU};
    tbl[2]  = '{5'd3, 5'd5, 5'd5, 1, 0, 0, 0, 0, 1, O_LU};
    tbl[3]  = '{5'd0, 5'd0, 5'd0, 1, 0, 0, 0, 0, 1, O_DEF};
    tbl[4]  = '{5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 0, 1, O_DEF};
    tbl[5]  = '{5'd5, 5'd6, 5'd7, 1, 0, 0, 0, 0, 1, O_DEF};
    tbl[6]  = '{5'd1, 5'd2, 5'd3, 0, 1, 0, 0, 0, 1, O_RED};
    tbl[7]  = '{5'd9, 5'd4, 5'd9, 1, 0, 1, 0, 0, 1, O_RED};
    tbl[8]  = '{5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 0, O_MW};
    tbl[9]  = '{5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, 1, O_DEF};
    tbl[10] = '{5'd8, 5'd1, 5'd8, 1, 1, 0, 0, 1, 0, O_MW};
    tbl[11] = '{5'd8, 5'd1, 5'd8, 1, 0, 1, 1, 0, 1, O_RED};

    idle_inputs();
    rst_n = 1'b0;
    #1;
    do_reset();

    // ---- constant vector table (all in RUN) ----
    for (int i = 0; i < 12; i++) begin
      Rs_D = tbl[i].rs; Rt_D = tbl[i].rt; WriteReg_E = tbl[i].wr;
      MemtoReg_E = tbl[i].mtr_e; J_M = tbl[i].j; Jr_M = tbl[i].jr;
      MemtoReg_M = tbl[i].mtr_m; MemWrite_M = tbl[i].mw_m; mem_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("table_%0d", i), dut_out, tbl[i].exp);
      adv();
    end
    idle_inputs();
    sample("after_table");
    adv();

    // ---- divide: stall DIV_CYCLES cycles, single go pulse ----
    go_count = 0; ene_low = 0;
    div_start_E = 1;
    for (int k = 0; k <= DIV_CYCLES; k++) begin
      sample("div_model");
      go_count += int'(div_go);
      ene_low  += int'(!EN_E);
      if (k == 0) chk("div_go_first", 12'(div_go), 12'd1);
      if (k == DIV_CYCLES) chk("div_release_en_e_busy", {10'b0, EN_E, div_busy}, 12'b11);
      adv();
    end
    div_start_E = 0;
    sample("div_after");
    chk("div_after_idle", dut_out, O_DEF);
    chk("div_go_count", 12'(go_count), 12'd1);
    chk("div_stall_cycles", 12'(ene_low), 12'(DIV_CYCLES));
    adv();

    // ---- memory wait with timeout ----
    MemWrite_M = 1; mem_ready = 0;
    for (int k = 1; k <= 20; k++) begin
      sample("mw_model");
      chk("mw_stall", {6'b0, EN_F, EN_D, EN_E, EN_M, EN_W, CLR_W}, 12'b000011);
      if (k == 16) chk("mw_tmo_not_yet", 12'(mem_timeout), 12'd0);
      if (k == 17) chk("mw_tmo_set", 12'(mem_timeout), 12'd1);
      adv();
    end
    mem_ready = 1;
    sample("mw_release");
    chk("mw_release_out", dut_out, O_DEF | 12'd1);
    adv();
    MemWrite_M = 0;
    sample("mw_sticky");
    chk("mw_tmo_sticky", 12'(mem_timeout), 12'd1);
    adv();
    do_reset();
    sample("tmo_cleared");
    chk("tmo_cleared_out", dut_out, O_DEF);
    adv();

    // ---- jump at DIV_WAIT cycle 3 ----
    div_start_E = 1;
    for (int k = 0; k < 3; k++) begin
      sample("jdiv_model");
      adv();
    end
    J_M = 1;
    sample("jdiv_flush_model");
    chk("jdiv_flush", {7'b0, CLR_D, CLR_E, CLR_M, EN_E, EN_F}, 12'b11111);
    adv();
    J_M = 0; div_start_E = 0;
    sample("jdiv_after");
    chk("jdiv_run", dut_out, O_DEF);
    adv();

    // ---- mem_wait + redirect: held until mem_ready ----
    J_M = 1; MemtoReg_M = 1; mem_ready = 0;
    for (int k = 0; k < 3; k++) begin
      sample("mwj_model");
      chk("mwj_stall", dut_out, O_MW);
      adv();
    end
    mem_ready = 1;
    sample("mwj_release_model");
    chk("mwj_flush", dut_out, O_RED);
    adv();
    idle_inputs();

    // ---- reset at DIV_WAIT cycle 5 ----
    div_start_E = 1;
    for (int k = 0; k < 5; k++) begin
      sample("rdiv_model");
      adv();
    end
    rst_n = 1'b0;
    sample("rdiv_reset_model");
    chk("rdiv_reset_busy", {11'b0, div_busy}, 12'd0);
    adv();
    div_start_E = 0;
    sample("rdiv_reset_hold");
    adv();
    rst_n = 1'b1;
    sample("rdiv_after");
    chk("rdiv_after_run", dut_out, O_DEF);
    adv();

    // ---- randomized traffic ----
    burst = 0;
    for (int c = 0; c < 4000; c++) begin
      Rs_D        = 5'($urandom_range(0, 3));
      Rt_D        = 5'($urandom_range(0, 3));
      WriteReg_E  = 5'($urandom_range(0, 3));
      MemtoReg_E  = ($urandom_range(0, 99) < 40);
      div_start_E = ($urandom_range(0, 99) < 8);
      J_M         = ($urandom_range(0, 99) < 5);
      Jr_M        = ($urandom_range(0, 99) < 3);
      MemtoReg_M  = ($urandom_range(0, 99) < 25);
      MemWrite_M  = ($urandom_range(0, 99) < 10);
      mem_ready   = ($urandom_range(0, 99) < 60);
      if (burst == 0 && $urandom_range(0, 199) == 0) burst = $urandom_range(10, 22);
      if (burst > 0) begin
        MemtoReg_M = 1; mem_ready = 0; burst--;
      end
      rst_n = ($urandom_range(0, 399) != 0);
      sample("random");
      adv();
    end
    rst_n = 1'b1;
    idle_inputs();
    sample("final");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
